// File: rtl/modport_fifo.sv
// Single-clock synchronous FIFO with registered read data.
// Illegal accesses are dropped and flagged in the same cycle.
module modport_fifo #(
    parameter int DATA_WIDTH          = 8,
    parameter int DEPTH               = 16,
    parameter int ALMOST_FULL_THRESH  = 14,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_overflow,
    output logic                  fifo_underflow,
    output logic                  fifo_almost_full,
    output logic                  fifo_almost_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_COUNT   = (AW+1)'(ALMOST_FULL_THRESH);
    localparam logic [AW:0] AE_COUNT   = (AW+1)'(ALMOST_EMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  wr_accept;
    logic                  rd_accept;

    // Flags come from the registered count, but reset forces the idle view at once.
    assign fifo_full         = ~rst & (count == FULL_COUNT);
    assign fifo_empty        = rst | (count == '0);
    assign fifo_almost_full  = ~rst & (count >= AF_COUNT);
    assign fifo_almost_empty = rst | (count <= AE_COUNT);

    assign fifo_overflow  = wr_en & fifo_full & ~rst;
    assign fifo_underflow = rd_en & fifo_empty & ~rst;

    assign wr_accept = wr_en & ~rst & (count != FULL_COUNT);
    assign rd_accept = rd_en & ~rst & (count != '0);

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_accept) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_modport_fifo.sv
// Self-checking bench for modport_fifo: a directed vector table, directed
// corner-case sequences and randomized traffic against a queue-based model.
module tb_modport_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFT   = 14;
    localparam int AET   = 2;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_overflow;
    logic          fifo_underflow;
    logic          fifo_almost_full;
    logic          fifo_almost_empty;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: a plain queue plus the last value read out.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_dout;

    typedef struct {
        logic          rst;
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        logic          e_empty;
        logic          e_full;
        logic          e_af;
        logic          e_ae;
        logic          e_ovf;
        logic          e_unf;
        logic [DW-1:0] e_dout;
    } vec_t;

    vec_t vecs[13];

    modport_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .ALMOST_FULL_THRESH(AFT),
        .ALMOST_EMPTY_THRESH(AET)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .data_in(data_in),
        .rd_en(rd_en),
        .data_out(data_out),
        .fifo_full(fifo_full),
        .fifo_empty(fifo_empty),
        .fifo_overflow(fifo_overflow),
        .fifo_underflow(fifo_underflow),
        .fifo_almost_full(fifo_almost_full),
        .fifo_almost_empty(fifo_almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock of stimulus: pre-edge flags and post-edge data_out checked against the model.
    task automatic applyStimulus(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
        int  n;
        logic rd_ok;
        logic wr_ok;
        @(negedge clk);
        rst     = r;
        wr_en   = w;
        rd_en   = rd;
        data_in = d;
        #1;
        n = model_q.size();
        checkOutput("fifo_empty",        32'(fifo_empty),        32'(r || n == 0));
        checkOutput("fifo_full",         32'(fifo_full),         32'(!r && n == DEPTH));
        checkOutput("fifo_almost_full",  32'(fifo_almost_full),  32'(!r && n >= AFT));
        checkOutput("fifo_almost_empty", 32'(fifo_almost_empty), 32'(r || n <= AET));
        checkOutput("fifo_overflow",     32'(fifo_overflow),     32'(!r && w && n == DEPTH));
        checkOutput("fifo_underflow",    32'(fifo_underflow),    32'(!r && rd && n == 0));
        @(posedge clk);
        if (r) begin
            model_q.delete();
            model_dout = '0;
        end else begin
            rd_ok = rd && (n > 0);
            wr_ok = w && (n < DEPTH);
            if (rd_ok) model_dout = model_q.pop_front();
            if (wr_ok) model_q.push_back(d);
        end
        #1;
        checkOutput("data_out", 32'(data_out), 32'(model_dout));
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        model_dout = '0;

        vecs[0]  = '{1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA2};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA3};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA4};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 8'hB5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA4};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hB5};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hB5};

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rst     = vecs[i].rst;
            wr_en   = vecs[i].wr;
            rd_en   = vecs[i].rd;
            data_in = vecs[i].din;
            #1;
            checkOutput("vec fifo_empty",        32'(fifo_empty),        32'(vecs[i].e_empty));
            checkOutput("vec fifo_full",         32'(fifo_full),         32'(vecs[i].e_full));
            checkOutput("vec fifo_almost_full",  32'(fifo_almost_full),  32'(vecs[i].e_af));
            checkOutput("vec fifo_almost_empty", 32'(fifo_almost_empty), 32'(vecs[i].e_ae));
            checkOutput("vec fifo_overflow",     32'(fifo_overflow),     32'(vecs[i].e_ovf));
            checkOutput("vec fifo_underflow",    32'(fifo_underflow),    32'(vecs[i].e_unf));
            @(posedge clk);
            #1;
            checkOutput("vec data_out", 32'(data_out), 32'(vecs[i].e_dout));
        end

        // Reset with both requests high, then underflow on an empty FIFO.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h77);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h78);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);

        // Fill with 0x01..0x10, watching almost-full and full appear.
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'(i));
            checkOutput("fill almost_full", 32'(fifo_almost_full), 32'(i >= AFT));
            checkOutput("fill full",        32'(fifo_full),        32'(i == DEPTH));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hAA);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);

        // Steady simultaneous traffic at 8 entries with pointer wrap.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b1, 8'(8'h60 + i));
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h90 + i));
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hEE);
        while (model_q.size() > 0) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hC3);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);

        // Reset in the middle of traffic discards everything.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h33);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("post-reset data_out", 32'(data_out), 32'h33);

        // Randomized traffic; write bias shifts so both full and empty are visited.
        for (int i = 0; i < 800; i++) begin
            int bias;
            bias = ((i / 100) % 2 == 0) ? 75 : 25;
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 99) < bias),
                          ($urandom_range(0, 99) >= bias),
                          8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/modport_fifo.md
Name: modport_fifo

Overview:
- Single-clock synchronous FIFO with registered read data.
- Status outputs: full, empty, almost-full, almost-empty, overflow and underflow.
- Sits between an independent write-side agent and read-side agent that share one clock.
- Rejected (illegal) accesses are flagged in the same cycle they occur.

Parameters:
- DATA_WIDTH, 8, width of data_in and data_out.
- DEPTH, 16, number of storage entries; must be a power of two, at least 4.
- ALMOST_FULL_THRESH, 14, fifo_almost_full asserts when occupancy >= this value.
- ALMOST_EMPTY_THRESH, 2, fifo_almost_empty asserts when occupancy <= this value.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- data_in  input  DATA_WIDTH  write data.
- rd_en  input  1  read request.
- data_out  output  DATA_WIDTH  registered read data.
- fifo_full  output  1  occupancy == DEPTH.
- fifo_empty  output  1  occupancy == 0.
- fifo_overflow  output  1  write attempted while full.
- fifo_underflow  output  1  read attempted while empty.
- fifo_almost_full  output  1  occupancy >= ALMOST_FULL_THRESH.
- fifo_almost_empty  output  1  occupancy <= ALMOST_EMPTY_THRESH.

Behaviour:
- State: storage array of DEPTH x DATA_WIDTH, write pointer, read pointer (log2(DEPTH) bits each, natural wrap) and occupancy count (log2(DEPTH)+1 bits).
- Reset (rst=1 sampled at a clk edge):
  - Pointers, count and data_out go to 0.
  - Memory contents are don't-care.
  - While rst=1: fifo_empty=1, fifo_almost_empty=1, fifo_full=0, fifo_almost_full=0, fifo_overflow=0, fifo_underflow=0.
  - wr_en and rd_en are ignored during reset.
  - Reset mid-operation discards all stored data immediately.
- Accepted write: wr_en=1 and fifo_full=0.
  - data_in is stored at the write pointer.
  - Write pointer increments, wrapping DEPTH-1 -> 0.
- Accepted read: rd_en=1 and fifo_empty=0.
  - data_out <= mem[read pointer] at the clock edge, so data is valid the cycle after the request (1-cycle latency).
  - Read pointer increments with wrap.
  - data_out holds its last value when no read is accepted.
- Count update: +1 for an accepted write only, -1 for an accepted read only, unchanged when both or neither are accepted.
- Status flags are derived combinationally from the registered count; they update the cycle after the access.
- fifo_overflow = wr_en & fifo_full & ~rst (combinational, same cycle).
  - The write is dropped; storage and pointers are unchanged by it.
- fifo_underflow = rd_en & fifo_empty & ~rst (combinational, same cycle).
  - The read is dropped; data_out is unchanged.
- Simultaneous read and write:
  - Not full and not empty: both are accepted, count unchanged, read returns the oldest entry.
  - Full: the read is accepted, the write is rejected and fifo_overflow=1 (flags are evaluated on pre-edge state).
  - Empty: the write is accepted, the read is rejected and fifo_underflow=1. No fall-through.
- Ordering: strict first-in first-out. Data written is never altered until it is read or reset.

Test Plan:
- Reset check: assert rst for 2 cycles with wr_en=rd_en=1 -> fifo_empty=1, fifo_full=0, fifo_almost_empty=1, overflow/underflow=0, data_out=0.
- Fill and drain: write 0x01..0x10 (16 writes) -> fifo_almost_full rises after the 14th write and fifo_full after the 16th. Then read 16 times -> data_out returns 0x01..0x10 in order, one cycle after each rd_en, and fifo_empty=1 after the last read.
- Overflow: with the FIFO full, drive wr_en=1 and data_in=0xAA -> fifo_overflow=1 in that cycle, count stays 16, and 0xAA never appears on subsequent reads.
- Underflow: after reset, drive rd_en=1 -> fifo_underflow=1 in the same cycle, data_out stays 0, fifo_empty stays 1.
- Simultaneous access at 8 entries: wr_en=rd_en=1 for 20 cycles with an incrementing pattern -> count stays 8, no flag changes, pointers wrap and order is preserved. At full with both asserted -> one entry is read and fifo_overflow=1. At empty with both asserted -> fifo_underflow=1 and count becomes 1.
- Mid-operation reset: write 5 entries, pulse rst for 1 cycle -> fifo_empty=1. Then write 0x33 and read -> data_out=0x33.
